// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch
// conditions, forwarding selects and the EX/MEM register bundle.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus_4;
        logic [4:0]  dr_num;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        reg_write;
        logic        mem_read;
        logic [2:0]  funct3;
    } ex_mem_t;

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU; shifts use the low five bits of the B operand.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  ALUControl,
    input  logic        unused_tie,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = SrcB[4:0];

    always_comb begin
        result = '0;
        unique case (ALUControl)
            ALU_ADD:   result = SrcA + SrcB;
            ALU_SUB:   result = SrcA - SrcB;
            ALU_AND:   result = SrcA & SrcB;
            ALU_OR:    result = SrcA | SrcB;
            ALU_XOR:   result = SrcA ^ SrcB;
            ALU_SLT:   result = {31'b0, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU:  result = {31'b0, SrcA < SrcB};
            ALU_SLL:   result = SrcA << shamt;
            ALU_SRL:   result = SrcA >> shamt;
            ALU_SRA:   result = $unsigned($signed(SrcA) >>> shamt);
            ALU_PASSB: result = SrcB;
            default:   result = {31'b0, unused_tie & 1'b0};
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register with stall, flush and reset.
module exec_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        EN,
    input  logic        Flush,
    input  logic [31:0] R_1,
    input  logic [31:0] R_2,
    input  logic [31:0] ImmExt,
    input  logic [31:0] PC,
    input  logic [31:0] PC_plus_4,
    input  logic [4:0]  R_1_num,
    input  logic [4:0]  R_2_num,
    input  logic [4:0]  DR_num,
    input  logic [1:0]  ResultSrc,
    input  logic        MemWrite,
    input  logic        ALUSrc,
    input  logic        RegWrite,
    input  logic        Jump,
    input  logic        Branch,
    input  logic [3:0]  ALUControl,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] WB_Result,
    output logic        w_PCSrc,
    output logic [31:0] w_PCTarget,
    output logic [4:0]  w_R_1_num,
    output logic [4:0]  w_R_2_num,
    output logic [31:0] ALUResult,
    output logic [31:0] WriteData,
    output logic [31:0] PC_plus_4_M,
    output logic [4:0]  DR_num_M,
    output logic [1:0]  ResultSrc_M,
    output logic        MemWrite_M,
    output logic        RegWrite_M,
    output logic        MemRead_M,
    output logic [2:0]  funct3_M
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_y;
    logic        cond;
    ex_mem_t     d;
    ex_mem_t     q;

    always_comb begin
        src_a = R_1;
        unique case (ForwardA)
            FWD_WB:  src_a = WB_Result;
            FWD_MEM: src_a = MEM_ALUResult;
            default: src_a = R_1;
        endcase
    end

    always_comb begin
        fwd_b = R_2;
        unique case (ForwardB)
            FWD_WB:  fwd_b = WB_Result;
            FWD_MEM: fwd_b = MEM_ALUResult;
            default: fwd_b = R_2;
        endcase
    end

    assign src_b = ALUSrc ? ImmExt : fwd_b;

    alu u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControl),
        .unused_tie (1'b0),
        .result     (alu_y)
    );

    // Branches compare register operands, never the immediate.
    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            BR_EQ:   cond = (src_a == fwd_b);
            BR_NE:   cond = (src_a != fwd_b);
            BR_LT:   cond = ($signed(src_a) < $signed(fwd_b));
            BR_GE:   cond = ($signed(src_a) >= $signed(fwd_b));
            BR_LTU:  cond = (src_a < fwd_b);
            BR_GEU:  cond = (src_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign w_PCSrc    = Jump | (Branch & cond);
    assign w_PCTarget = (Jump & ALUSrc) ? ((src_a + ImmExt) & ~32'd1)
                                        : (PC + ImmExt);
    assign w_R_1_num  = R_1_num;
    assign w_R_2_num  = R_2_num;

    assign d = '{
        alu_result: alu_y,
        write_data: fwd_b,
        pc_plus_4:  PC_plus_4,
        dr_num:     DR_num,
        result_src: ResultSrc,
        mem_write:  MemWrite,
        reg_write:  RegWrite,
        mem_read:   MemRead,
        funct3:     funct3
    };

    // A flush only has to kill side effects; data fields keep their value.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (Flush) begin
            q.reg_write  <= 1'b0;
            q.mem_write  <= 1'b0;
            q.mem_read   <= 1'b0;
            q.result_src <= '0;
            q.dr_num     <= '0;
        end else if (EN) begin
            q <= d;
        end
    end

    assign ALUResult   = q.alu_result;
    assign WriteData   = q.write_data;
    assign PC_plus_4_M = q.pc_plus_4;
    assign DR_num_M    = q.dr_num;
    assign ResultSrc_M = q.result_src;
    assign MemWrite_M  = q.mem_write;
    assign RegWrite_M  = q.reg_write;
    assign MemRead_M   = q.mem_read;
    assign funct3_M    = q.funct3;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: vector table for ALU/forwarding/branch
// plus hand sequences for reset, flush and stall.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset, EN, Flush;
    logic [31:0] R_1, R_2, ImmExt, PC, PC_plus_4;
    logic [4:0]  R_1_num, R_2_num, DR_num;
    logic [1:0]  ResultSrc;
    logic        MemWrite, ALUSrc, RegWrite, Jump, Branch, MemRead;
    logic [3:0]  ALUControl;
    logic [2:0]  funct3;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] MEM_ALUResult, WB_Result;
    logic        w_PCSrc;
    logic [31:0] w_PCTarget;
    logic [4:0]  w_R_1_num, w_R_2_num;
    logic [31:0] ALUResult, WriteData, PC_plus_4_M;
    logic [4:0]  DR_num_M;
    logic [1:0]  ResultSrc_M;
    logic        MemWrite_M, RegWrite_M, MemRead_M;
    logic [2:0]  funct3_M;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk(clk), .reset(reset), .EN(EN), .Flush(Flush),
        .R_1(R_1), .R_2(R_2), .ImmExt(ImmExt), .PC(PC),
        .PC_plus_4(PC_plus_4), .R_1_num(R_1_num), .R_2_num(R_2_num),
        .DR_num(DR_num), .ResultSrc(ResultSrc), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Jump(Jump),
        .Branch(Branch), .ALUControl(ALUControl), .MemRead(MemRead),
        .funct3(funct3), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MEM_ALUResult(MEM_ALUResult), .WB_Result(WB_Result),
        .w_PCSrc(w_PCSrc), .w_PCTarget(w_PCTarget),
        .w_R_1_num(w_R_1_num), .w_R_2_num(w_R_2_num),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .PC_plus_4_M(PC_plus_4_M), .DR_num_M(DR_num_M),
        .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
        .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M),
        .funct3_M(funct3_M)
    );

    typedef struct {
        logic [31:0] r1, r2, imm, mem, wb;
        logic [1:0]  fa, fb;
        logic        alusrc, branch, jump;
        logic [3:0]  ctl;
        logic [2:0]  f3;
        logic [31:0] exp_alu, exp_wd, exp_tgt;
        logic        exp_pcsrc;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        EN = 1'b1; Flush = 1'b0; reset = 1'b0;
        R_1 = 0; R_2 = 0; ImmExt = 0; PC = 32'h100; PC_plus_4 = 32'h104;
        R_1_num = 5'd1; R_2_num = 5'd2; DR_num = 0; ResultSrc = 0;
        MemWrite = 0; ALUSrc = 0; RegWrite = 0; Jump = 0; Branch = 0;
        ALUControl = 0; MemRead = 0; funct3 = 3'b010;
        ForwardA = 0; ForwardB = 0; MEM_ALUResult = 0; WB_Result = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] r1, r2, imm, mem, wb,
                       input logic [1:0] fa, fb,
                       input logic alusrc, branch, jump,
                       input logic [3:0] ctl, input logic [2:0] f3,
                       input logic [31:0] ea, ew, et, input logic ep);
        vec_t t;
        t.r1 = r1; t.r2 = r2; t.imm = imm; t.mem = mem; t.wb = wb;
        t.fa = fa; t.fb = fb; t.alusrc = alusrc; t.branch = branch;
        t.jump = jump; t.ctl = ctl; t.f3 = f3;
        t.exp_alu = ea; t.exp_wd = ew; t.exp_tgt = et; t.exp_pcsrc = ep;
        v.push_back(t);
    endtask

    initial begin
        idle();
        // reset wins over Flush and EN with live inputs
        reset = 1; Flush = 1; EN = 1;
        R_1 = 32'h55; R_2 = 32'h66; RegWrite = 1; MemWrite = 1;
        MemRead = 1; ResultSrc = 2'b11; DR_num = 5'd9; funct3 = 3'b101;
        tick();
        chk("rst_alu", ALUResult, 0);
        chk("rst_wd", WriteData, 0);
        chk("rst_pc4", PC_plus_4_M, 0);
        chk("rst_dr", {27'b0, DR_num_M}, 0);
        chk("rst_ctl", {ResultSrc_M, MemWrite_M, RegWrite_M, MemRead_M}, 0);
        chk("rst_f3", {29'b0, funct3_M}, 0);
        idle();

        //   r1 r2 imm mem wb fa fb asrc br jmp ctl f3 | alu wd tgt pcsrc
        add(5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 3'b010, 2, 3, 32'h100, 0);
        add(0, 0, 4, 32'h10, 0, 2, 0, 1, 0, 0, 4'b0000, 3'b010,
            32'h14, 0, 32'h104, 0);
        add(0, 0, 4, 0, 32'h20, 1, 0, 1, 0, 0, 4'b0000, 3'b010,
            32'h24, 0, 32'h104, 0);
        add(32'hFFFFFFFF, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 3'b100,
            32'hFFFFFFFE, 1, 32'h110, 1);
        add(32'hFFFFFFFF, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 3'b110,
            32'hFFFFFFFE, 1, 32'h110, 0);
        add(32'h203, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000, 3'b010,
            32'h203, 0, 32'h202, 1);
        add(32'h80000000, 0, 31, 0, 0, 0, 0, 1, 0, 0, 4'b1001, 3'b010,
            32'hFFFFFFFF, 0, 32'h11F, 0);
        add(32'h80000000, 31, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 3'b010,
            1, 31, 32'h100, 0);
        add(32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 3'b010,
            1, 1, 32'h100, 0);
        add(32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 3'b010,
            0, 1, 32'h100, 0);
        add(1, 32'h24, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0111, 3'b010,
            32'h10, 32'h24, 32'h100, 0);
        add(32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 3'b010,
            32'hFF00, 32'h0FF0, 32'h100, 0);
        add(32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 3'b010,
            32'h00F0, 32'h0FF0, 32'h100, 0);
        add(32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 3'b010,
            32'hFFF0, 32'h0FF0, 32'h100, 0);
        add(7, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 3'b010,
            32'h55, 32'h55, 32'h100, 0);
        add(7, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 3'b010,
            0, 32'h55, 32'h100, 0);
        add(1, 9, 0, 32'h100, 0, 0, 2, 0, 0, 0, 4'b0000, 3'b010,
            32'h101, 32'h100, 32'h100, 0);
        add(2, 9, 0, 0, 32'h30, 0, 1, 0, 0, 0, 4'b0000, 3'b010,
            32'h32, 32'h30, 32'h100, 0);
        add(6, 9, 0, 32'h40, 32'h50, 3, 3, 0, 0, 0, 4'b0000, 3'b010,
            32'hF, 9, 32'h100, 0);
        add(5, 5, 8, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 3'b000,
            32'hD, 5, 32'h108, 1);
        add(7, 8, 8, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001,
            32'hF, 8, 32'h108, 1);
        add(7, 7, 8, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b010,
            32'hE, 7, 32'h108, 0);
        add(32'hFFFFFFFF, 1, 8, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b101,
            0, 1, 32'h108, 0);
        add(32'hFFFFFFFF, 1, 8, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b111,
            0, 1, 32'h108, 1);

        foreach (v[i]) begin
            R_1 = v[i].r1; R_2 = v[i].r2; ImmExt = v[i].imm;
            MEM_ALUResult = v[i].mem; WB_Result = v[i].wb;
            ForwardA = v[i].fa; ForwardB = v[i].fb; ALUSrc = v[i].alusrc;
            Branch = v[i].branch; Jump = v[i].jump;
            ALUControl = v[i].ctl; funct3 = v[i].f3;
            RegWrite = i[0]; DR_num = 5'(i + 1);
            PC_plus_4 = 32'h104 + 32'(i);
            #1;
            chk($sformatf("pcsrc[%0d]", i), {31'b0, w_PCSrc},
                {31'b0, v[i].exp_pcsrc});
            chk($sformatf("tgt[%0d]", i), w_PCTarget, v[i].exp_tgt);
            tick();
            chk($sformatf("alu[%0d]", i), ALUResult, v[i].exp_alu);
            chk($sformatf("wd[%0d]", i), WriteData, v[i].exp_wd);
            chk($sformatf("rw[%0d]", i), {31'b0, RegWrite_M},
                {31'b0, i[0]});
            chk($sformatf("dr[%0d]", i), {27'b0, DR_num_M}, 32'(i + 1));
            chk($sformatf("pc4[%0d]", i), PC_plus_4_M, 32'h104 + 32'(i));
            chk($sformatf("f3m[%0d]", i), {29'b0, funct3_M},
                {29'b0, v[i].f3});
        end
        chk("hz_nums", {w_R_1_num, w_R_2_num}, {5'd1, 5'd2});

        // stall holds loaded data
        idle();
        R_1 = 5; R_2 = 3; ALUControl = 4'b0001; RegWrite = 1;
        DR_num = 5'd7; MemRead = 1; ResultSrc = 2'b01;
        tick();
        EN = 0; R_1 = 100; R_2 = 50; RegWrite = 0; DR_num = 5'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_alu", ALUResult, 2);
            chk("hold_wd", WriteData, 3);
            chk("hold_ctl", {27'b0, DR_num_M, RegWrite_M}, {27'b0, 5'd7, 1'b1});
        end

        // flush kills controls, then stall keeps them killed
        idle();
        RegWrite = 1; MemWrite = 1; MemRead = 1; ResultSrc = 2'b10;
        DR_num = 5'd9;
        tick();
        chk("pre_flush", {ResultSrc_M, MemWrite_M, RegWrite_M, MemRead_M},
            {2'b10, 3'b111});
        Flush = 1;
        tick();
        chk("flush_ctl", {ResultSrc_M, MemWrite_M, RegWrite_M, MemRead_M}, 0);
        chk("flush_dr", {27'b0, DR_num_M}, 0);
        Flush = 0; EN = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_ctl", {27'b0, DR_num_M, RegWrite_M, MemWrite_M}, 0);
        end

        // flush wins even while stalled
        idle();
        RegWrite = 1; MemWrite = 1; DR_num = 5'd4;
        tick();
        EN = 0; Flush = 1;
        tick();
        chk("flush_en0", {27'b0, DR_num_M, RegWrite_M, MemWrite_M}, 0);

        // reset mid-stall, then idle stage stays quiet
        idle();
        R_1 = 9; RegWrite = 1; MemWrite = 1; DR_num = 5'd5;
        tick();
        EN = 0; reset = 1;
        tick();
        chk("rst_stall_alu", ALUResult, 0);
        chk("rst_stall_ctl", {27'b0, DR_num_M, RegWrite_M, MemWrite_M}, 0);
        idle();
        tick();
        chk("idle_ctl", {30'b0, RegWrite_M, MemWrite_M}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
